instr_sequencer: RTL
====================

Name: instr_sequencer

Overview:
Multi-cycle fetch/execute controller for the 5-bit-opcode microprocessor. It sits between the program ROM, the instruction register and the combinational instruction decoder. It latches opcodes and gates the decoder's clock-enable strobes so each one fires only in the correct phase. It also provides the 3-cycle path for the two-cycle memory moves (0x10 MOV A,#addr and 0x11 MOV #addr,A) and a retired-instruction counter.

Parameters:
INSTR_WIDTH, 5, opcode width
MOVRD_OP, 5'h10, opcode of MOV A,#addr
MOVWR_OP, 5'h11, opcode of MOV #addr,A
RST_OP, 5'h1F, opcode of RST
NOP_OP, 5'h0C, IR value after reset
CNT_WIDTH, 16, retired-instruction counter width

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
RUN  in  1  level: free-run while 1
STEP  in  1  1-cycle pulse: execute one instruction from IDLE
INSTR_IN  in  INSTR_WIDTH  opcode from program ROM at current PC
IR_OUT  out  INSTR_WIDTH  latched opcode, drives decoder INSTRUCTION
DEC_CE_ACC, DEC_REG_WR, DEC_CE_RAM, DEC_CE_PC, DEC_CE_STACK, DEC_CE_PORTA  in  1 each  raw decoder strobes
CE_ACC, REG_WR, CE_RAM, CE_PC, CE_STACK, CE_PORTA  out  1 each  phase-gated strobes to datapath
PC_INC  out  1  increment PC this cycle
PC_CLR  out  1  clear PC to 0 this cycle
ADDR_LATCH  out  1  latch immediate address into RAM address register
STATE  out  3  current FSM state
BUSY  out  1  1 in any state except IDLE
RETIRED  out  CNT_WIDTH  count of completed instructions

Behaviour:
- Reset (nRST=0, async): STATE=IDLE, IR_OUT=NOP_OP, RETIRED=0. All strobes, PC_INC, PC_CLR, ADDR_LATCH and BUSY are 0. Reset mid-instruction aborts it with no further strobes.
- State encoding: IDLE=3'b000, FETCH=3'b001, EXEC=3'b010, MEM=3'b011.
- IDLE: all outputs 0. Transition to FETCH if RUN=1 or STEP=1. A STEP pulse is registered as one pending step.
- FETCH: IR_OUT<=INSTR_IN at the end of the cycle. All strobes 0. Next state is EXEC.
- EXEC, single-cycle opcodes (everything except MOVRD_OP, MOVWR_OP and RST_OP):
  - Each output strobe equals its DEC_* input.
  - PC_INC = ~DEC_CE_PC, so jump, call and ret load the PC instead of incrementing it.
  - RETIRED increments.
  - Next state is FETCH if RUN=1, else IDLE. The pending step is consumed.
- EXEC, MOVRD_OP/MOVWR_OP:
  - ADDR_LATCH=1.
  - CE_ACC, REG_WR, CE_RAM and PC_INC are forced to 0. CE_PC=DEC_CE_PC, so the operand word is stepped.
  - Next state is MEM.
- MEM:
  - For MOVRD: CE_ACC=DEC_CE_ACC and REG_WR=DEC_REG_WR.
  - For MOVWR: CE_RAM=DEC_CE_RAM.
  - PC_INC=1 and RETIRED increments.
  - Next state is FETCH if RUN=1, else IDLE.
- EXEC, RST_OP: PC_CLR=1 and all strobes 0. RETIRED increments. Next state is IDLE regardless of RUN.
- Latency: 2 cycles per single-cycle instruction and 3 per two-cycle move.
- RUN falling mid-instruction: the current instruction completes, then the FSM enters IDLE.
- STEP while RUN=1 is ignored. STEP while not in IDLE is ignored.
- Every strobe is asserted for exactly one cycle per instruction. No strobe is ever asserted in FETCH or IDLE.
- RETIRED wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- An X or unused opcode is passed through the decoder; the sequencer treats it as single-cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding constants
  - opcode constants: NOP, MOVRD, MOVWR, RST, JMP 5'h0E, CALL 5'h14, RET 5'h15
  - INSTR_WIDTH
- One sub-module, retire_counter: a CNT_WIDTH wrapping counter with enable and async active-low clear.
- FSM, IR register and strobe gating stay in instr_sequencer.

Test Plan:
- Reset then RUN=1 with ROM stream 0x05 (ADD), 0x0C:
  - STATE goes IDLE→FETCH→EXEC→FETCH→EXEC.
  - CE_ACC is high only in the first EXEC, with PC_INC=1.
  - RETIRED=2 after 5 cycles.
- Opcode 0x10 with DEC_CE_ACC=1:
  - EXEC has ADDR_LATCH=1 and CE_ACC=0.
  - MEM has CE_ACC=1 and PC_INC=1.
  - Exactly 3 cycles; RETIRED +1.
- Opcode 0x11 with DEC_CE_RAM=1: CE_RAM is high only in MEM, never in EXEC.
- Opcode 0x0E with DEC_CE_PC=1: in EXEC, CE_PC=1 and PC_INC=0.
- Opcode 0x1F while RUN=1: PC_CLR=1 for one cycle, then STATE=IDLE and stays there until RUN is re-seen high after IDLE.
- RUN=0 with one STEP pulse, then nRST low during the following MEM of a 0x10:
  - STEP executes one instruction and returns to IDLE.
  - The async reset drives all strobes to 0 immediately, with IR_OUT=0x0C and RETIRED=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the 5-bit-opcode CPU: opcodes, FSM state encoding,
// and the strobe bundle that the sequencer gates.
package cpu_pkg;

    localparam int unsigned INSTR_WIDTH = 5;

    localparam logic [INSTR_WIDTH-1:0] OP_NOP   = 5'h0C;
    localparam logic [INSTR_WIDTH-1:0] OP_JMP   = 5'h0E;
    localparam logic [INSTR_WIDTH-1:0] OP_MOVRD = 5'h10;
    localparam logic [INSTR_WIDTH-1:0] OP_MOVWR = 5'h11;
    localparam logic [INSTR_WIDTH-1:0] OP_CALL  = 5'h14;
    localparam logic [INSTR_WIDTH-1:0] OP_RET   = 5'h15;
    localparam logic [INSTR_WIDTH-1:0] OP_RST   = 5'h1F;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_FETCH = 3'b001,
        ST_EXEC  = 3'b010,
        ST_MEM   = 3'b011
    } state_e;

    typedef struct packed {
        logic acc;
        logic reg_wr;
        logic ram;
        logic pc;
        logic stack;
        logic porta;
    } strobes_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Signal bundle between the sequencer and its ROM/decoder/datapath environment.
interface instr_sequencer_if #(
    parameter int unsigned INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
    parameter int unsigned CNT_WIDTH   = 16
);
    logic                   RUN;
    logic                   STEP;
    logic [INSTR_WIDTH-1:0] INSTR_IN;
    logic [INSTR_WIDTH-1:0] IR_OUT;
    logic                   DEC_CE_ACC, DEC_REG_WR, DEC_CE_RAM;
    logic                   DEC_CE_PC, DEC_CE_STACK, DEC_CE_PORTA;
    logic                   CE_ACC, REG_WR, CE_RAM, CE_PC, CE_STACK, CE_PORTA;
    logic                   PC_INC;
    logic                   PC_CLR;
    logic                   ADDR_LATCH;
    logic [2:0]             STATE;
    logic                   BUSY;
    logic [CNT_WIDTH-1:0]   RETIRED;

    modport master (
        output RUN, STEP, INSTR_IN,
        output DEC_CE_ACC, DEC_REG_WR, DEC_CE_RAM, DEC_CE_PC, DEC_CE_STACK, DEC_CE_PORTA,
        input  IR_OUT, CE_ACC, REG_WR, CE_RAM, CE_PC, CE_STACK, CE_PORTA,
        input  PC_INC, PC_CLR, ADDR_LATCH, STATE, BUSY, RETIRED
    );

    modport slave (
        input  RUN, STEP, INSTR_IN,
        input  DEC_CE_ACC, DEC_REG_WR, DEC_CE_RAM, DEC_CE_PC, DEC_CE_STACK, DEC_CE_PORTA,
        output IR_OUT, CE_ACC, REG_WR, CE_RAM, CE_PC, CE_STACK, CE_PORTA,
        output PC_INC, PC_CLR, ADDR_LATCH, STATE, BUSY, RETIRED
    );

endinterface

// File: rtl/retire_counter.sv
// Wrapping count of completed instructions; no overflow indication.
module retire_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 nCLR,
    input  logic                 EN,
    output logic [CNT_WIDTH-1:0] COUNT
);

    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            cnt_q <= '0;
        end else if (EN) begin
            cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign COUNT = cnt_q;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute controller: latches opcodes into IR and phase-gates the raw
// decoder strobes; two-cycle memory moves take an extra MEM phase.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned            INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
    parameter logic [INSTR_WIDTH-1:0] MOVRD_OP    = OP_MOVRD,
    parameter logic [INSTR_WIDTH-1:0] MOVWR_OP    = OP_MOVWR,
    parameter logic [INSTR_WIDTH-1:0] RST_OP      = OP_RST,
    parameter logic [INSTR_WIDTH-1:0] NOP_OP      = OP_NOP,
    parameter int unsigned            CNT_WIDTH   = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    instr_sequencer_if.slave  bus
);

    state_e                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    strobes_t               dec, ce;
    logic                   pc_inc, pc_clr, addr_latch, retire;

    assign dec = {bus.DEC_CE_ACC, bus.DEC_REG_WR, bus.DEC_CE_RAM,
                  bus.DEC_CE_PC, bus.DEC_CE_STACK, bus.DEC_CE_PORTA};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            ir_q    <= NOP_OP;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        ce         = '0;
        pc_inc     = 1'b0;
        pc_clr     = 1'b0;
        addr_latch = 1'b0;
        retire     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.RUN || bus.STEP) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ir_d    = bus.INSTR_IN;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                // Unknown or X opcodes fall into default and run as single-cycle.
                case (ir_q)
                    MOVRD_OP, MOVWR_OP: begin
                        addr_latch = 1'b1;
                        ce.pc      = dec.pc;
                        state_d    = ST_MEM;
                    end
                    RST_OP: begin
                        pc_clr  = 1'b1;
                        retire  = 1'b1;
                        state_d = ST_IDLE;
                    end
                    default: begin
                        ce      = dec;
                        pc_inc  = ~dec.pc;
                        retire  = 1'b1;
                        state_d = bus.RUN ? ST_FETCH : ST_IDLE;
                    end
                endcase
            end
            ST_MEM: begin
                if (ir_q == MOVRD_OP) begin
                    ce.acc    = dec.acc;
                    ce.reg_wr = dec.reg_wr;
                end else begin
                    ce.ram    = dec.ram;
                end
                pc_inc  = 1'b1;
                retire  = 1'b1;
                state_d = bus.RUN ? ST_FETCH : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.IR_OUT     = ir_q;
    assign bus.STATE      = state_q;
    assign bus.BUSY       = (state_q != ST_IDLE);
    assign bus.CE_ACC     = ce.acc;
    assign bus.REG_WR     = ce.reg_wr;
    assign bus.CE_RAM     = ce.ram;
    assign bus.CE_PC      = ce.pc;
    assign bus.CE_STACK   = ce.stack;
    assign bus.CE_PORTA   = ce.porta;
    assign bus.PC_INC     = pc_inc;
    assign bus.PC_CLR     = pc_clr;
    assign bus.ADDR_LATCH = addr_latch;

    retire_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_retire (
        .CLK  (CLK),
        .nCLR (nRST),
        .EN   (retire),
        .COUNT(bus.RETIRED)
    );

endmodule
